// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one single-port memory between an instruction-fetch
// port and a data port, with fetch anti-starvation, flush discard and a bus timeout.
module mem_port_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // Handshake: a requester holds req/addr/data stable while its stall is high. Its
  // valid pulse marks completion; in that same cycle it may present its next request
  // (or drop req), which is arbitrated at once. On the memory side mem_req stays high
  // until mem_ack, and an ack seen while no transaction is open is ignored.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic [TW-1:0] tmo_cnt;
  logic          flush_seen;
  logic          grant_dm, grant_if;
  logic          busy, done_ok, done_tmo, done, suppress;

  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE) begin
      if (dm_req && !(if_req && streak == SW'(MAX_STREAK))) grant_dm = 1'b1;
      else if (if_req)                                       grant_if = 1'b1;
    end
  end

  // Timeout fires on the edge that closes the TIMEOUT-th busy cycle without an ack;
  // an ack in that very cycle still wins.
  assign busy     = (state != IDLE);
  assign done_ok  = busy && mem_ack;
  assign done_tmo = busy && !mem_ack && (tmo_cnt == TW'(TIMEOUT - 1));
  assign done     = done_ok || done_tmo;
  assign suppress = flush_seen || if_flush;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_dm)      state_nxt = BUSY_DM;
        else if (grant_if) state_nxt = BUSY_IF;
      end
      BUSY_IF, BUSY_DM: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      streak     <= '0;
      tmo_cnt    <= '0;
      flush_seen <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_rdata   <= '0;
      dm_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;

      if (!if_req || grant_if)                          streak <= '0;
      else if (grant_dm && streak != SW'(MAX_STREAK))   streak <= streak + SW'(1);

      if (grant_dm || grant_if) begin
        mem_req    <= 1'b1;
        mem_we     <= grant_dm && dm_we;
        mem_addr   <= grant_dm ? dm_addr : if_addr;
        mem_wdata  <= grant_dm ? dm_wdata : '0;
        tmo_cnt    <= '0;
        flush_seen <= 1'b0;
      end else if (busy) begin
        if (state == BUSY_IF && if_flush) flush_seen <= 1'b1;
        if (done) begin
          mem_req <= 1'b0;
          if (done_tmo) err <= 1'b1;
          if (state == BUSY_DM) begin
            dm_valid <= 1'b1;
            if (done_tmo)     dm_rdata <= '0;
            else if (!mem_we) dm_rdata <= mem_rdata;
          end else if (!suppress) begin
            if_valid <= 1'b1;
            if_rdata <= done_tmo ? '0 : mem_rdata;
          end
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

  assign if_stall  = if_req && !if_valid;
  assign dm_stall  = dm_req && !dm_valid;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random
// two-port traffic scored against a transaction-level model of ports and memory.
module tb_mem_port_arbiter;

  localparam int MAX_STREAK = 4;
  localparam int TIMEOUT    = 15;
  localparam logic [1:0] IDLE_CODE = 2'd0;

  logic        Clk, Reset;
  logic        if_req, if_flush, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, if_stall, dm_valid, dm_stall;
  logic        mem_req, mem_we, mem_ack, err;
  logic [1:0]  state_dbg;

  mem_port_arbiter #(.MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory responder ----------------
  logic [31:0] mem_arr [logic [31:0]];
  int          lat_min, lat_max;
  logic        mute, stray_ack;

  function automatic logic [31:0] fill(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC3C3_0000;
  endfunction

  initial begin
    int cnt, cur_lat;
    mem_arr[32'h40] = 32'h2008_000A;
    mem_arr[32'h80] = 32'hFFFF_FFFF;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    cnt       = 0;
    cur_lat   = 1;
    forever begin
      @(negedge Clk);
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end else if (mem_req && !mute) begin
        if (cnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
        cnt++;
        if (cnt >= cur_lat) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_arr[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : fill(mem_addr);
          end
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        cnt       = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks, n_err;
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];
  logic [31:0] ref_mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_mem_req"}, mem_req, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk1({tag, "_if_valid"}, if_valid, 1'b0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
    chk1({tag, "_dm_valid"}, dm_valid, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk({tag, "_state"}, 32'(state_dbg), 32'(IDLE_CODE));
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] exp_if_rdata, dm_model, e;
  logic        prev_mr, prev_if_req, prev_dm_req, prev_dm_we, exp_dm;
  logic [31:0] prev_if_addr, prev_dm_addr, prev_dm_wdata, a, d;
  bit          gq[$];
  int          run, if_left, dm_left, n_if_done, n_dm_done;

  initial begin
    n_checks = 0; n_err = 0;
    lat_min = 1; lat_max = 1; mute = 1'b0; stray_ack = 1'b0;

    // Reset state
    do_reset();
    chk_zero("reset");

    // Fetch only, minimum latency
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    chk1("f1_mem_req", mem_req, 1'b1);
    chk("f1_mem_addr", mem_addr, 32'h40);
    chk1("f1_mem_we", mem_we, 1'b0);
    chk1("f1_if_stall_c1", if_stall, 1'b1);
    chk1("f1_if_valid_c1", if_valid, 1'b0);
    tick();
    chk1("f1_if_valid_c2", if_valid, 1'b1);
    chk("f1_if_rdata", if_rdata, 32'h2008_000A);
    chk1("f1_if_stall_c2", if_stall, 1'b0);
    exp_if_rdata = 32'h2008_000A;
    if_req = 1'b0;
    tick();
    chk1("f1_if_valid_c3", if_valid, 1'b0);
    chk1("f1_mem_req_c3", mem_req, 1'b0);

    // Simultaneous requests: data write wins, fetch follows after one IDLE cycle;
    // a flush during BUSY_DM must not disturb the later fetch.
    if_req = 1'b1; if_addr = 32'h44;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'h55;
    tick();
    chk1("sim_mem_req", mem_req, 1'b1);
    chk1("sim_mem_we", mem_we, 1'b1);
    chk("sim_mem_addr", mem_addr, 32'h10);
    chk("sim_mem_wdata", mem_wdata, 32'h55);
    if_flush = 1'b1;
    tick();
    chk1("sim_dm_valid", dm_valid, 1'b1);
    chk("sim_dm_rdata_held", dm_rdata, 32'h0);
    chk1("sim_mem_req_idle", mem_req, 1'b0);
    chk1("sim_if_stall", if_stall, 1'b1);
    if_flush = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk1("sim_if_granted", mem_req, 1'b1);
    chk("sim_if_addr", mem_addr, 32'h44);
    chk1("sim_if_we", mem_we, 1'b0);
    chk1("sim_dm_valid_once", dm_valid, 1'b0);
    tick();
    chk1("sim_if_valid", if_valid, 1'b1);
    chk("sim_if_rdata", if_rdata, fill(32'h44));
    chk("sim_mem_written", mem_arr.exists(32'h10) ? mem_arr[32'h10] : 32'hX, 32'h55);
    exp_if_rdata = fill(32'h44);
    if_req = 1'b0;
    tick();

    // Starvation: fetch waits behind a continuous data stream
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    prev_mr = mem_req;
    gq.delete();
    for (int c = 0; c < 200 && !(gq.size() == 10 && !mem_req); c++) begin
      tick();
      if (mem_req && !prev_mr) gq.push_back(mem_addr < 32'h200);
      prev_mr = mem_req;
      if (if_valid) begin
        chk("starve_if_rdata", if_rdata, fill(if_addr));
        exp_if_rdata = fill(if_addr);
        if_addr = if_addr + 32'h4;
      end
      if (dm_valid) begin
        chk("starve_dm_rdata", dm_rdata, fill(dm_addr));
        dm_addr = dm_addr + 32'h4;
      end
      if (gq.size() == 10 && !mem_req) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
    chk("starve_grant_count", gq.size(), 32'd10);
    for (int g = 0; g < gq.size(); g++)
      chk1($sformatf("starve_grant%0d", g), gq[g], (g % 5) == 4);
    tick();

    // Flush during BUSY_IF: result discarded, fetch re-arbitrates with new address
    lat_min = 2; lat_max = 2;
    if_req = 1'b1; if_addr = 32'h80;
    tick();
    chk1("fl_mem_req", mem_req, 1'b1);
    chk("fl_mem_addr", mem_addr, 32'h80);
    if_flush = 1'b1; if_addr = 32'hC0;
    tick();
    chk1("fl_if_valid_c2", if_valid, 1'b0);
    if_flush = 1'b0;
    tick();
    chk1("fl_if_valid_c3", if_valid, 1'b0);
    chk("fl_if_rdata_kept", if_rdata, exp_if_rdata);
    chk1("fl_mem_req_done", mem_req, 1'b0);
    chk1("fl_if_stall", if_stall, 1'b1);
    tick();
    chk1("fl_regrant", mem_req, 1'b1);
    chk("fl_new_addr", mem_addr, 32'hC0);
    tick();
    tick();
    chk1("fl_if_valid_new", if_valid, 1'b1);
    chk("fl_if_rdata_new", if_rdata, fill(32'hC0));
    if_req = 1'b0;
    tick();

    // Ack in the last allowed busy cycle counts as success
    lat_min = TIMEOUT; lat_max = TIMEOUT;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h24;
    repeat (TIMEOUT) tick();
    chk1("edge_mem_req", mem_req, 1'b1);
    chk1("edge_dm_valid_early", dm_valid, 1'b0);
    tick();
    chk1("edge_dm_valid", dm_valid, 1'b1);
    chk("edge_dm_rdata", dm_rdata, fill(32'h24));
    chk1("edge_err", err, 1'b0);
    dm_req = 1'b0;
    tick();

    // Timeout on a data read
    mute = 1'b1;
    dm_req = 1'b1; dm_addr = 32'h28;
    repeat (TIMEOUT) tick();
    chk1("tmo_mem_req_c15", mem_req, 1'b1);
    chk1("tmo_err_c15", err, 1'b0);
    tick();
    chk1("tmo_err", err, 1'b1);
    chk1("tmo_dm_valid", dm_valid, 1'b1);
    chk("tmo_dm_rdata", dm_rdata, 32'h0);
    chk1("tmo_mem_req", mem_req, 1'b0);
    dm_req = 1'b0; mute = 1'b0;
    lat_min = 1; lat_max = 1;
    if_req = 1'b1; if_addr = 32'h48;
    tick();
    tick();
    chk1("tmo_after_if_valid", if_valid, 1'b1);
    chk1("tmo_err_sticky", err, 1'b1);
    if_req = 1'b0;
    repeat (3) tick();
    chk1("tmo_err_sticky2", err, 1'b1);

    // Reset mid-transaction, then a stray ack
    mute = 1'b1;
    dm_req = 1'b1; dm_addr = 32'h2C;
    tick();
    chk1("rst_busy", mem_req, 1'b1);
    Reset = 1'b1; dm_req = 1'b0;
    tick();
    chk_zero("rst_mid");
    Reset = 1'b0; mute = 1'b0;
    tick();
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    chk1("stray_dm_valid", dm_valid, 1'b0);
    chk1("stray_if_valid", if_valid, 1'b0);
    chk1("stray_mem_req", mem_req, 1'b0);
    chk("stray_state", 32'(state_dbg), 32'(IDLE_CODE));
    chk("stray_dm_rdata", dm_rdata, 32'h0);
    tick();
    chk1("stray_mem_req2", mem_req, 1'b0);

    // Random two-port traffic against the transaction model
    do_reset();
    lat_min = 1; lat_max = 3;
    if_left = 40; dm_left = 40; n_if_done = 0; n_dm_done = 0;
    run = 0; dm_model = '0;
    prev_mr = 1'b0; prev_if_req = 1'b0; prev_dm_req = 1'b0; prev_dm_we = 1'b0;
    prev_if_addr = '0; prev_dm_addr = '0; prev_dm_wdata = '0;
    exp_if_q.delete(); exp_dm_q.delete();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      // a new grant is judged on the requests seen in the previous cycle
      if (mem_req && !prev_mr) begin
        exp_dm = prev_dm_req && !(prev_if_req && run == MAX_STREAK);
        chk1("rnd_grant_owner", mem_addr[31:28] == 4'h2, exp_dm);
        if (exp_dm) begin
          chk("rnd_dm_addr", mem_addr, prev_dm_addr);
          chk1("rnd_dm_we", mem_we, prev_dm_we);
          if (prev_dm_we) chk("rnd_dm_wdata", mem_wdata, prev_dm_wdata);
        end else begin
          chk("rnd_if_addr", mem_addr, prev_if_addr);
          chk1("rnd_if_we", mem_we, 1'b0);
        end
        if (!prev_if_req || !exp_dm) run = 0;
        else if (run < MAX_STREAK)   run++;
      end else if (!prev_if_req) begin
        run = 0;
      end
      prev_mr = mem_req;

      if (if_valid) begin
        n_if_done++;
        if (exp_if_q.size() == 0) chk1("rnd_if_valid_extra", if_valid, 1'b0);
        else begin
          e = exp_if_q.pop_front();
          chk("rnd_if_rdata", if_rdata, e);
        end
      end
      if (dm_valid) begin
        n_dm_done++;
        if (exp_dm_q.size() == 0) chk1("rnd_dm_valid_extra", dm_valid, 1'b0);
        else begin
          e = exp_dm_q.pop_front();
          chk("rnd_dm_rdata", dm_rdata, e);
        end
      end

      if (if_valid || !if_req) begin
        if_req = 1'b0;
        if (if_left > 0 && $urandom_range(2, 0) != 0) begin
          a = 32'h1000_0000 + 32'($urandom_range(255, 0)) * 4;
          if_req = 1'b1; if_addr = a;
          exp_if_q.push_back(fill(a));
          if_left--;
        end
      end
      if (dm_valid || !dm_req) begin
        dm_req = 1'b0;
        if (dm_left > 0 && $urandom_range(3, 0) != 0) begin
          a = 32'h2000_0000 + 32'($urandom_range(7, 0)) * 4;
          d = $urandom;
          dm_req = 1'b1; dm_addr = a;
          dm_we = ($urandom_range(1, 0) == 1);
          dm_wdata = d;
          if (dm_we) begin
            ref_mem[a] = d;
          end else begin
            dm_model = ref_mem.exists(a) ? ref_mem[a] : fill(a);
          end
          exp_dm_q.push_back(dm_model);
          dm_left--;
        end
      end

      prev_if_req = if_req; prev_if_addr = if_addr;
      prev_dm_req = dm_req; prev_dm_addr = dm_addr;
      prev_dm_we = dm_we; prev_dm_wdata = dm_wdata;

      if (if_left == 0 && dm_left == 0 && !if_req && !dm_req && !mem_req &&
          exp_if_q.size() == 0 && exp_dm_q.size() == 0) break;
    end
    chk("rnd_if_done", n_if_done, 32'd40);
    chk("rnd_dm_done", n_dm_done, 32'd40);
    chk("rnd_if_q_left", exp_if_q.size(), 32'd0);
    chk("rnd_dm_q_left", exp_dm_q.size(), 32'd0);
    chk1("rnd_err", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
